text_overlay_ctrl: RTL and testbench

// Character-screen controller that sequences the 8x16 overlay font lookup. It owns a

---
 rtl/text_overlay_ctrl_if.sv | 11 +
 rtl/text_overlay_ctrl.sv | 144 ++++++++++++++
 tb/tb_text_overlay_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_overlay_ctrl_if.sv
// Host write port of the text overlay controller: valid/ready handshake carrying
// a cell index and the ASCII code to store there.
interface text_overlay_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/text_overlay_ctrl.sv
// Character-screen controller: maps the beam position to a text cell, fetches the
// cell's code from a single-port RAM shared with host writes and a clear engine.
module text_overlay_ctrl #(
  parameter int         COLS     = 40,
  parameter int         ROWS     = 30,
  parameter int         X0       = 0,
  parameter int         Y0       = 0,
  parameter logic [5:0] FG       = 6'b111100,
  parameter logic [5:0] BG       = 6'b000001,
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic                clk,
  input  logic                i_reset_n,
  input  logic [11:0]         i_h,
  input  logic [11:0]         i_v,
  text_overlay_ctrl_if.slave  wr,
  input  logic                i_clear,
  output logic                o_busy,
  output logic [2:0]          o_font_col,
  output logic [3:0]          o_font_row,
  output logic [7:0]          o_font_ascii,
  input  logic                i_font_pix,
  output logic                o_ce_pixel,
  output logic [1:0]          o_r,
  output logic [1:0]          o_g,
  output logic [1:0]          o_b
);

  localparam int CELLS  = COLS * ROWS;
  localparam int STAGES = 3;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [11:0] hx, vy;
  logic        active, fetch;
  logic [10:0] cell_addr;

  assign hx        = i_h - 12'(X0);
  assign vy        = i_v - 12'(Y0);
  assign active    = (hx < 12'(8 * COLS)) && (vy < 12'(16 * ROWS));
  assign fetch     = active && (hx[2:0] == 3'd0);
  assign cell_addr = 11'(32'(vy[11:4]) * COLS + 32'(hx[11:3]));

  // ---------------- clear FSM ----------------
  state_t      state, state_n;
  logic [10:0] ctr, ctr_n;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state <= CLEAR;
      ctr   <= '0;
    end else begin
      state <= state_n;
      ctr   <= ctr_n;
    end
  end

  always_comb begin
    state_n = state;
    ctr_n   = ctr;
    case (state)
      IDLE: if (i_clear) begin
        state_n = CLEAR;
        ctr_n   = '0;
      end
      CLEAR: begin
        if (i_clear) ctr_n = '0;
        else if (!fetch) begin
          if (ctr == 11'(CELLS - 1)) begin
            state_n = IDLE;
            ctr_n   = '0;
          end else begin
            ctr_n = ctr + 11'd1;
          end
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  assign o_busy      = (state == CLEAR);
  assign wr.wr_ready = i_reset_n && !fetch && (state == IDLE);

  // ---------------- character RAM ----------------
  // The display fetch owns the single port on its cycle; otherwise clear, then host.
  logic [7:0]  mem [CELLS];
  logic [7:0]  ram_q;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [7:0]  ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ctr;
    ram_wdata = CLR_CHAR;
    if (state == CLEAR && !fetch) begin
      ram_we = 1'b1;
    end else if (wr.wr_valid && wr.wr_ready && (wr.wr_addr < 11'(CELLS))) begin
      ram_we    = 1'b1;
      ram_waddr = wr.wr_addr;
      ram_wdata = wr.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (fetch)  ram_q <= mem[cell_addr];
  end

  // ---------------- display pipeline ----------------
  logic [STAGES:1] vld_pipe;
  logic            fetch_q;
  logic [2:0]      col_q;
  logic [3:0]      row_q;
  logic [5:0]      rgb;

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      vld_pipe     <= '0;
      fetch_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      o_font_col   <= '0;
      o_font_row   <= '0;
      o_font_ascii <= '0;
      o_ce_pixel   <= 1'b0;
      rgb          <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], active};
      fetch_q    <= fetch;
      col_q      <= hx[2:0];
      row_q      <= vy[3:0];
      o_font_col <= col_q;
      o_font_row <= row_q;
      // code stays held for the remaining 7 pixels of the cell
      if (fetch_q) o_font_ascii <= ram_q;
      o_ce_pixel <= vld_pipe[STAGES];
      rgb        <= vld_pipe[STAGES] ? (i_font_pix ? FG : BG) : 6'd0;
    end
  end

  assign {o_r, o_g, o_b} = rgb;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Self-checking bench for text_overlay_ctrl: scoreboard of expected font requests
// and overlay pixels against a byte model of the character RAM and a font model.
module tb_text_overlay_ctrl;
  localparam logic [5:0] FG = 6'b111100;
  localparam logic [5:0] BG = 6'b000001;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [11:0] i_h, i_v;
  logic        i_clear;
  logic        o_busy;
  logic [2:0]  o_font_col;
  logic [3:0]  o_font_row;
  logic [7:0]  o_font_ascii;
  logic        font_pix;
  logic        o_ce_pixel;
  logic [1:0]  o_r, o_g, o_b;

  text_overlay_ctrl_if wr_if ();

  text_overlay_ctrl dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_h(i_h), .i_v(i_v), .wr(wr_if),
    .i_clear(i_clear), .o_busy(o_busy), .o_font_col(o_font_col),
    .o_font_row(o_font_row), .o_font_ascii(o_font_ascii), .i_font_pix(font_pix),
    .o_ce_pixel(o_ce_pixel), .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  always #5 clk = ~clk;

  function automatic logic fpix(input logic [7:0] a, input logic [3:0] r, input logic [2:0] c);
    return a[c] ^ r[0];
  endfunction

  // font ROM: one-cycle registered response
  always @(posedge clk) font_pix <= fpix(o_font_ascii, o_font_row, o_font_col);

  typedef struct {
    logic [11:0] h, v;
    logic        ce, rchk, fchk;
    logic [5:0]  rgb;
    logic [7:0]  asc;
    logic [2:0]  col;
    logic [3:0]  row;
  } exp_t;

  exp_t        q_out[$], q_font[$];
  logic [11:0] ph[$], pv[$];
  logic [7:0]  model [1200];
  int          checks = 0, failures = 0;

  task automatic run_scan(input string tag);
    exp_t        e, g;
    logic [7:0]  held = 8'h00;
    logic        held_v = 1'b0;
    logic        act;
    int          n = ph.size();
    q_out.delete(); q_font.delete();
    for (int k = 0; k < n + 3; k++) begin
      if (k < n) begin
        act = (ph[k] < 12'd320) && (pv[k] < 12'd480);
        if (act && ph[k][2:0] == 3'd0) begin
          held   = model[int'(pv[k] >> 4) * 40 + int'(ph[k] >> 3)];
          held_v = 1'b1;
        end
        e.h = ph[k]; e.v = pv[k]; e.ce = act;
        e.rchk = !act || held_v;
        e.fchk = act && held_v;
        e.asc = held; e.col = ph[k][2:0]; e.row = pv[k][3:0];
        e.rgb = act ? (fpix(held, pv[k][3:0], ph[k][2:0]) ? FG : BG) : 6'd0;
        i_h = ph[k]; i_v = pv[k];
        q_out.push_back(e); q_font.push_back(e);
      end else begin
        i_h = 12'hFFF; i_v = 12'hFFF;
      end
      @(posedge clk); #1;
      if (q_font.size() == 2 || (k >= n && q_font.size() > 0)) begin
        g = q_font.pop_front();
        if (g.fchk) begin
          checks++;
          if ({o_font_ascii, o_font_col, o_font_row} !== {g.asc, g.col, g.row}) begin
            failures++;
            $display("FAIL %s_font h=%0d v=%0d got asc=%h col=%0d row=%0d exp asc=%h col=%0d row=%0d",
                     tag, g.h, g.v, o_font_ascii, o_font_col, o_font_row, g.asc, g.col, g.row);
          end
        end
      end
      if (q_out.size() == 4 || (k >= n && q_out.size() > 0)) begin
        g = q_out.pop_front();
        if (g.rchk) begin
          checks++;
          if ({o_ce_pixel, o_r, o_g, o_b} !== {g.ce, g.rgb}) begin
            failures++;
            $display("FAIL %s_pix h=%0d v=%0d got ce=%b rgb=%b exp ce=%b rgb=%b",
                     tag, g.h, g.v, o_ce_pixel, {o_r, o_g, o_b}, g.ce, g.rgb);
          end
        end
      end
    end
    ph.delete(); pv.delete();
  endtask

  task automatic scan_all_cells(input string tag);
    for (int cy = 0; cy < 30; cy++)
      for (int cx = 0; cx < 40; cx++) begin
        ph.push_back(12'(cx * 8)); pv.push_back(12'(cy * 16));
      end
    run_scan(tag);
  endtask

  task automatic host_write(input logic [10:0] a, input logic [7:0] d);
    int n = 0;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = a; wr_if.wr_data = d; #1;
    while (!wr_if.wr_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!wr_if.wr_ready) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%0d got ready=0 exp ready=1", a);
    end
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    i_reset_n = 1'b0; i_h = 12'd0; i_v = 12'd0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({o_ce_pixel, o_r, o_g, o_b, o_font_col, o_font_row, o_font_ascii, wr_if.wr_ready} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got ce=%b rgb=%b font=%h/%h/%h ready=%b exp all 0",
               o_ce_pixel, {o_r, o_g, o_b}, o_font_ascii, o_font_col, o_font_row, wr_if.wr_ready);
    end
    i_reset_n = 1'b1; i_h = 12'hFFF; i_v = 12'hFFF; #1;
    checks++;
    if ({o_busy, wr_if.wr_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_busy got busy=%b ready=%b exp busy=1 ready=0", o_busy, wr_if.wr_ready);
    end
    while (o_busy && n < 5000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 1200) begin
      failures++;
      $display("FAIL reset_clear_len got %0d cycles exp 1200", n);
    end
    checks++;
    if (wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got %b exp 1", wr_if.wr_ready);
    end
  endtask

  task automatic test_display();
    host_write(11'd0, 8'h41); model[0] = 8'h41;
    host_write(11'd1, 8'h5A); model[1] = 8'h5A;
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 16; h++) begin
        ph.push_back(12'(h)); pv.push_back(12'(v));
      end
    run_scan("display");
  endtask

  task automatic test_fetch_stall();
    i_h = 12'd7; i_v = 12'd0;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 11'd2; wr_if.wr_data = 8'h43;
    @(posedge clk); #1;
    i_h = 12'd8; #1;
    checks++;
    if (wr_if.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready got %b exp 0", wr_if.wr_ready);
    end
    @(posedge clk); #1;
    i_h = 12'd9; #1;
    checks++;
    if (wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_accept got %b exp 1", wr_if.wr_ready);
    end
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0; i_h = 12'hFFF; i_v = 12'hFFF;
    model[2] = 8'h43;
  endtask

  task automatic test_oob_write();
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 11'd1200; wr_if.wr_data = 8'h58; #1;
    checks++;
    if (wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL oob_ready got %b exp 1", wr_if.wr_ready);
    end
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
    scan_all_cells("oob_cells");
  endtask

  task automatic test_window();
    host_write(11'd39, 8'h7E);   model[39]   = 8'h7E;
    host_write(11'd1160, 8'h3C); model[1160] = 8'h3C;
    for (int h = 312; h < 326; h++) begin ph.push_back(12'(h)); pv.push_back(12'd0); end
    for (int v = 464; v < 484; v++) begin ph.push_back(12'd0); pv.push_back(12'(v)); end
    ph.push_back(12'd320); pv.push_back(12'd480);
    ph.push_back(12'd4095); pv.push_back(12'd5);
    run_scan("window");
  endtask

  task automatic test_clear_restart();
    int n = 0;
    host_write(11'd7, 8'h5A); model[7] = 8'h5A;
    i_clear = 1'b1; @(posedge clk); #1; i_clear = 1'b0; #1;
    checks++;
    if ({o_busy, wr_if.wr_ready} !== 2'b10) begin
      failures++;
      $display("FAIL clear_start got busy=%b ready=%b exp busy=1 ready=0", o_busy, wr_if.wr_ready);
    end
    repeat (500) @(posedge clk);
    #1;
    i_clear = 1'b1; @(posedge clk); #1; i_clear = 1'b0;
    while (o_busy && n < 5000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 1200) begin
      failures++;
      $display("FAIL clear_restart_len got %0d cycles exp 1200", n);
    end
    for (int i = 0; i < 1200; i++) model[i] = 8'h20;
    scan_all_cells("restart_cells");
  endtask

  initial begin
    i_clear = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    for (int i = 0; i < 1200; i++) model[i] = 8'h20;
    test_reset();
    scan_all_cells("clear_fill");
    test_display();
    test_fetch_stall();
    test_oob_write();
    test_window();
    test_clear_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
